mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/wisc_mem_pkg.sv | 26 ++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wisc_mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wisc_mem_pkg : shared types and sizes for the I/D memory arbiter |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
package wisc_mem_pkg;

    localparam int ADDR_W            = 16;
    localparam int DATA_W            = 16;
    localparam int BLOCK_WORDS       = 8;
    localparam int BLOCK_OFFSET_BITS = 4;
    localparam int IDX_W             = 3;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FILL_ISSUE = 2'd1,
        FILL_WAIT  = 2'd2,
        WRITE      = 2'd3
    } state_t;

    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter : shares one word-wide memory port between I and D   |
// | cache fills and D-cache single-word writes. Revision 1.0         |
// +------------------------------------------------------------------+
module mem_arbiter #(
    parameter int BLOCK_WORDS = wisc_mem_pkg::BLOCK_WORDS
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_req,
    input  logic [wisc_mem_pkg::ADDR_W-1:0] i_addr,
    input  logic                            d_req,
    input  logic                            d_wr,
    input  logic [wisc_mem_pkg::ADDR_W-1:0] d_addr,
    input  logic [wisc_mem_pkg::DATA_W-1:0] d_wdata,
    output logic                            mem_en,
    output logic                            mem_wr,
    output logic [wisc_mem_pkg::ADDR_W-1:0] mem_addr,
    output logic [wisc_mem_pkg::DATA_W-1:0] mem_wdata,
    input  logic [wisc_mem_pkg::DATA_W-1:0] mem_rdata,
    input  logic                            mem_valid,
    output logic                            fill_we,
    output logic                            fill_sel,
    output logic [wisc_mem_pkg::IDX_W-1:0]  fill_idx,
    output logic [wisc_mem_pkg::DATA_W-1:0] fill_data,
    output logic                            i_done,
    output logic                            d_done
);
    import wisc_mem_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [IDX_W-1:0]    r_issue_cnt;
    logic [IDX_W-1:0]    r_ret_cnt;
    logic                r_grant_d;
    logic                r_last_d;
    logic [ADDR_W-1:0]   r_base;
    logic                r_i_done;
    logic                r_d_done;

    logic                w_grant;
    logic                w_pick_d;
    logic                w_fill_active;
    logic                w_fill_we;
    logic                w_issue_last;
    logic                w_ret_last;

    // The done cycle is still IDLE but the finishing requester holds req, so no grant then.
    assign w_grant       = (r_state == IDLE) & (i_req | d_req) & ~(r_i_done | r_d_done);
    assign w_pick_d      = d_req & (~i_req | ~r_last_d);
    assign w_fill_active = (r_state == FILL_ISSUE) | (r_state == FILL_WAIT);
    assign w_fill_we     = w_fill_active & mem_valid;
    assign w_issue_last  = (r_state == FILL_ISSUE) & (r_issue_cnt == LAST_IDX);
    assign w_ret_last    = w_fill_we & (r_ret_cnt == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_next_state = (w_pick_d && d_wr) ? WRITE : FILL_ISSUE;
                end
            end
            FILL_ISSUE: begin
                if (w_ret_last) begin
                    w_next_state = IDLE;
                end else if (w_issue_last) begin
                    w_next_state = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                if (w_ret_last) begin
                    w_next_state = IDLE;
                end
            end
            WRITE:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_grant_d   <= 1'b0;
            r_last_d    <= 1'b0;
            r_base      <= '0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
        end else begin
            r_i_done <= w_ret_last & ~r_grant_d;
            r_d_done <= (w_ret_last & r_grant_d) | (r_state == WRITE);
            if (w_grant) begin
                r_grant_d   <= w_pick_d;
                r_last_d    <= w_pick_d;
                r_base      <= block_base(w_pick_d ? d_addr : i_addr);
                r_issue_cnt <= '0;
                r_ret_cnt   <= '0;
            end
            if (r_state == FILL_ISSUE) begin
                r_issue_cnt <= r_issue_cnt + 3'd1;
            end
            if (w_fill_we) begin
                r_ret_cnt <= r_ret_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            FILL_ISSUE: begin
                mem_en   = 1'b1;
                mem_addr = r_base + ADDR_W'({r_issue_cnt, 1'b0});
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
        fill_we  = w_fill_we;
        fill_sel = w_fill_active & r_grant_d;
        fill_idx = w_fill_we ? r_ret_cnt : '0;
    end

    assign fill_data = mem_rdata;
    assign i_done    = r_i_done;
    assign d_done    = r_d_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_arbiter : scoreboard bench with a latency-programmable    |
// | memory model. Revision 1.0                                       |
// +------------------------------------------------------------------+
module tb_mem_arbiter;
    import wisc_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;
    logic        fill_we, fill_sel;
    logic [2:0]  fill_idx;
    logic [15:0] fill_data;
    logic        i_done, d_done;

    mem_arbiter #(.BLOCK_WORDS(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .fill_we(fill_we), .fill_sel(fill_sel), .fill_idx(fill_idx), .fill_data(fill_data),
        .i_done(i_done), .d_done(d_done)
    );

    initial forever #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int lat = 4;
    int n_issue = 0;
    int last_issue_cyc = -10;

    logic [32:0] exp_issue[$];
    logic [19:0] exp_fill[$];
    logic        exp_done[$];
    int          pend_due[$];
    logic [15:0] pend_addr[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic exp_fill_txn(input logic sel, input logic [15:0] a);
        logic [15:0] b;
        logic [15:0] ad;
        b = a & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            ad = b + 16'(2 * k);
            exp_issue.push_back({1'b0, ad, 16'h0000});
            exp_fill.push_back({sel, 3'(k), mem_f(ad)});
        end
        exp_done.push_back(sel);
    endtask

    task automatic exp_write_txn(input logic [15:0] a, input logic [15:0] d);
        exp_issue.push_back({1'b1, a, d});
        exp_done.push_back(1'b1);
    endtask

    // Memory model: each read returns lat cycles after issue, in order.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                mem_valid = 1'b1;
                mem_rdata = mem_f(pend_addr[0]);
                void'(pend_due.pop_front());
                void'(pend_addr.pop_front());
            end else begin
                mem_valid = 1'b0;
                mem_rdata = 16'h0000;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_en) begin
                    n_issue++;
                    if (!mem_wr) begin
                        pend_due.push_back(cyc + lat);
                        pend_addr.push_back(mem_addr);
                        if (mem_addr[3:0] != 4'h0) check("issue_gap", 64'(cyc), 64'(last_issue_cyc + 1));
                        last_issue_cyc = cyc;
                    end
                    if (exp_issue.size() == 0) check("issue_unexpected", 64'(exp_issue.size()), 64'd1);
                    else check("issue", {mem_wr, mem_addr, mem_wdata}, exp_issue.pop_front());
                end
                if (fill_we) begin
                    if (exp_fill.size() == 0) check("fill_unexpected", 64'(exp_fill.size()), 64'd1);
                    else check("fill", {fill_sel, fill_idx, fill_data}, exp_fill.pop_front());
                end
                if (i_done || d_done) begin
                    check("done_both", 64'(i_done & d_done), 64'd0);
                    if (exp_done.size() == 0) check("done_unexpected", 64'(exp_done.size()), 64'd1);
                    else check("done_sel", 64'(d_done), 64'(exp_done.pop_front()));
                end
            end
        end
    end

    task automatic run_i(input logic [15:0] a);
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        i_addr = a;
        i_req  = 1'b1;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (i_done) seen = 1'b1;
        end
        check("i_done_timeout", 64'(seen), 64'd1);
        @(posedge clk); #1;
        i_req  = 1'b0;
        i_addr = '0;
    endtask

    task automatic run_d(input logic wr, input logic [15:0] a, input logic [15:0] d);
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        d_wr    = wr;
        d_addr  = a;
        d_wdata = d;
        d_req   = 1'b1;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (d_done) seen = 1'b1;
        end
        check("d_done_timeout", 64'(seen), 64'd1);
        @(posedge clk); #1;
        d_req   = 1'b0;
        d_wr    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (exp_issue.size() + exp_fill.size() + exp_done.size() + pend_due.size() == 0) break;
        end
        repeat (3) @(negedge clk);
        check(tag, 64'(exp_issue.size() + exp_fill.size() + exp_done.size() + pend_due.size()), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, {mem_en, mem_wr, mem_addr, mem_wdata, fill_we, fill_sel, fill_idx, i_done, d_done}, 64'd0);
    endtask

    initial begin
        int n0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_outputs");
        rst_n = 1'b1;

        lat = 4;
        exp_fill_txn(1'b0, 16'h1236);
        run_i(16'h1236);
        drain("drain_i_fill");

        // Simultaneous requests: D first, then the still-pending I.
        exp_fill_txn(1'b1, 16'h4000);
        exp_fill_txn(1'b0, 16'h2468);
        fork
            run_i(16'h2468);
            run_d(1'b0, 16'h4000, 16'h0000);
        join
        drain("drain_both_d_first");

        exp_write_txn(16'h0080, 16'hBEEF);
        run_d(1'b1, 16'h0080, 16'hBEEF);
        drain("drain_write");

        // Previous grant was D, so I wins this tie.
        exp_fill_txn(1'b0, 16'h3000);
        exp_fill_txn(1'b1, 16'h5000);
        fork
            run_i(16'h3000);
            run_d(1'b0, 16'h5000, 16'h0000);
        join
        drain("drain_both_i_first");

        lat = 1;
        exp_fill_txn(1'b0, 16'h0F0A);
        run_i(16'h0F0A);
        drain("drain_lat1");

        lat = 10;
        exp_fill_txn(1'b1, 16'h7FF2);
        run_d(1'b0, 16'h7FF2, 16'h0000);
        drain("drain_lat10");

        // Abort a D fill after its third issue.
        lat = 4;
        exp_issue.push_back({1'b0, 16'h6000, 16'h0000});
        exp_issue.push_back({1'b0, 16'h6002, 16'h0000});
        exp_issue.push_back({1'b0, 16'h6004, 16'h0000});
        n0 = n_issue;
        @(posedge clk); #1;
        d_addr = 16'h6000;
        d_wr   = 1'b0;
        d_req  = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); #1;
            if (n_issue - n0 >= 3) break;
        end
        check("abort_issue_count", 64'(n_issue - n0), 64'd3);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort_async_outputs");
        d_req  = 1'b0;
        d_addr = '0;
        repeat (2) @(negedge clk);
        check_outputs_zero("abort_held_outputs");
        rst_n = 1'b1;
        drain("drain_abort_strays");

        // Reset restores last-grant to I, so D wins the tie.
        exp_fill_txn(1'b1, 16'h2200);
        exp_fill_txn(1'b0, 16'h1100);
        fork
            run_i(16'h1100);
            run_d(1'b0, 16'h2200, 16'h0000);
        join
        drain("drain_post_reset");

        // D write raised mid I fill waits for the fill to finish.
        exp_fill_txn(1'b0, 16'h3330);
        exp_write_txn(16'h0042, 16'h1234);
        fork
            run_i(16'h3330);
            begin
                repeat (4) @(posedge clk);
                run_d(1'b1, 16'h0042, 16'h1234);
            end
        join
        drain("drain_mid_fill_write");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
